clock_enable_sequencer: RTL and testbench
=========================================

Name: clock_enable_sequencer

Overview:
- Parametrised successor to the single-divider clock/reset generator.
- Runs entirely in the PLL output domain and produces NUM_CH divided clock-enable channels, each with a runtime-programmable ratio.
- Each channel has its own reset, released in staggered order after PLL lock. Loss of lock re-asserts all resets.
- Sits directly behind the PLL. It feeds the USB, VGA and any future slow domains as clock enables plus square-wave divided outputs.

Parameters:
- NUM_CH, 2, number of divided channels / reset outputs (1..8).
- DIV_W, 8, width of each channel's divide ratio.
- RST_CYCLES, 32, cycles from synced lock to release of channel 0 reset (>=1).
- STAGGER, 16, extra cycles between successive channel releases (>=0).

Ports:
- clk  input  1  PLL output clock; the only clock.
- reset_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  raw PLL lock, asynchronous to clk.
- div_ratio  input  NUM_CH*DIV_W  per-channel ratio R; channel i at bits [i*DIV_W +: DIV_W].
- div_load  input  NUM_CH  per-channel one-cycle strobe to capture div_ratio.
- ce_out  output  NUM_CH  one-cycle clock-enable pulse per channel.
- clk_div_out  output  NUM_CH  square wave toggling on each ce, period 2*R.
- rst_out  output  NUM_CH  active-high per-channel reset.
- all_ready  output  1  high when every rst_out is low.

Behaviour:
- reset_n low (async):
  - FSM = WAIT_LOCK; sync flops = 0; sequence counter = 0.
  - rst_out = all 1s; ce_out = 0; clk_div_out = 0; all_ready = 0.
  - Ratio registers = 1 on all channels.
- Lock sync: 2-flop synchroniser on pll_locked; lock_s is valid 2 cycles after the pin.
- FSM states:
  - WAIT_LOCK -> COUNT when lock_s = 1. Counter cleared.
  - COUNT: counter increments each cycle. rst_out[i] deasserts on the edge where counter reaches RST_CYCLES + i*STAGGER. Releases are therefore in index order, and equal when STAGGER = 0. After the last channel releases -> RUN.
  - RUN: holds; counter frozen.
  - Any state, lock_s = 0 -> WAIT_LOCK next edge. All rst_out re-assert on that edge; counter cleared; dividers cleared.
- Counter width: clog2(RST_CYCLES + (NUM_CH-1)*STAGGER + 1). It must not wrap in COUNT.
- all_ready: registered AND of ~rst_out; one cycle behind the last release.
- Divider i, per channel:
  - Held cleared while rst_out[i] = 1: cnt = 0, ce = 0, clk_div = 0.
  - Effective ratio R_eff = max(R, 1); R = 0 behaves as R = 1.
  - cnt counts 0..R_eff-1. At R_eff-1, ce_out[i] is high that cycle, cnt returns to 0 and clk_div_out[i] toggles.
  - First ce comes R_eff cycles after the rst_out[i] falling edge, including the release cycle. R_eff = 1 gives ce high every cycle and a clk_div period of 2.
  - Ratio update: div_load[i] captures the new ratio into a pending register. The pending value becomes active only at the next terminal count, so no shortened or glitched period occurs.
  - div_load while rst_out[i] = 1 applies immediately.
  - A second load before the terminal count overwrites the pending value; last one wins.
- All outputs are registered. There is no combinational path from any input to any output.

Optional Feature:
- Macro: CLKGEN_LOCK_FILTER_EN.
- Defined: WAIT_LOCK requires lock_s continuously high for 16 consecutive cycles before entering COUNT. A 4-bit filter counter clears on any lock_s low. Lock loss still drops to WAIT_LOCK immediately, unfiltered.
- Undefined: no filter; lock_s high enters COUNT on the next edge.

Test Plan:
- Defaults, reset_n released, pll_locked raised at cycle 0:
  - rst_out[0] falls at cycle 2+1+32.
  - rst_out[1] falls 16 cycles later.
  - all_ready rises one cycle after rst_out[1] falls.
  - With the filter macro, both release times are 16 cycles later.
- After release, R = 5 on channel 0 -> ce_out[0] pulses every 5 cycles, first at release+4. clk_div_out[0] has period 10 with 50% duty.
- R = 0 and R = 1 -> ce_out high every cycle; clk_div_out toggles every cycle.
- Change R from 4 to 7 mid-period -> current period completes at 4 cycles, next at 7. No ce is dropped or doubled.
- Drop pll_locked in RUN -> all rst_out high 3 cycles later; ce_out and clk_div_out 0. Re-raise lock -> full staggered sequence repeats.
- Assert reset_n low mid-COUNT -> outputs reach reset values with no clock edge needed. Sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/clock_enable_sequencer.sv
// Staggered per-channel reset release and clock-enable dividers behind the PLL.
// Optional lock filter: define CLKGEN_LOCK_FILTER_EN.
module clock_enable_sequencer #(
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 32,
  parameter int STAGGER    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       clk_div_out,
  output logic [NUM_CH-1:0]       rst_out,
  output logic                    all_ready
);

  localparam int LAST = RST_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int CW   = $clog2(LAST + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    COUNT,
    RUN
  } state_t;

  state_t              state;
  logic                lock_m;
  logic                lock_s;
  logic [CW-1:0]       seq_cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [NUM_CH-1:0]   rst_d;
`ifdef CLKGEN_LOCK_FILTER_EN
  logic [3:0]          filt;
  logic                filt_ok;
`endif

  assign cnt_nxt = seq_cnt + 1'b1;

  // Next reset vector; dividers key off this so the first ce lands on time.
  always_comb begin
    rst_d = rst_out;
    if (!lock_s) begin
      rst_d = '1;
    end else if (state == COUNT) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_nxt == CW'(RST_CYCLES + i * STAGGER)) rst_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      state     <= WAIT_LOCK;
      seq_cnt   <= '0;
      rst_out   <= '1;
      all_ready <= 1'b0;
`ifdef CLKGEN_LOCK_FILTER_EN
      filt      <= '0;
      filt_ok   <= 1'b0;
`endif
    end else begin
      lock_m    <= pll_locked;
      lock_s    <= lock_m;
      rst_out   <= rst_d;
      all_ready <= ~|rst_out;
      if (!lock_s) begin
        state   <= WAIT_LOCK;
        seq_cnt <= '0;
`ifdef CLKGEN_LOCK_FILTER_EN
        filt    <= '0;
        filt_ok <= 1'b0;
`endif
      end else begin
        unique case (state)
          WAIT_LOCK: begin
            seq_cnt <= '0;
`ifdef CLKGEN_LOCK_FILTER_EN
            if (filt_ok) state <= COUNT;
            else if (filt == 4'hf) filt_ok <= 1'b1;
            else filt <= filt + 4'd1;
`else
            state <= COUNT;
`endif
          end
          COUNT: begin
            seq_cnt <= cnt_nxt;
            if (cnt_nxt == CW'(LAST)) state <= RUN;
          end
          RUN: begin
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] pend;
    logic             pend_v;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    logic [DIV_W-1:0] r_in;
    logic             ce_q;
    logic             div_q;

    assign r_in           = div_ratio[g*DIV_W +: DIV_W];
    assign last           = (act == '0) ? '0 : act - 1'b1;
    assign ce_out[g]      = ce_q;
    assign clk_div_out[g] = div_q;

    // A pending ratio only takes effect at terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        act    <= DIV_W'(1);
        pend   <= '0;
        pend_v <= 1'b0;
        cnt    <= '0;
        ce_q   <= 1'b0;
        div_q  <= 1'b0;
      end else begin
        if (rst_d[g]) begin
          cnt   <= '0;
          ce_q  <= 1'b0;
          div_q <= 1'b0;
        end else if (cnt == last) begin
          cnt   <= '0;
          ce_q  <= 1'b1;
          div_q <= ~div_q;
          if (pend_v) begin
            act    <= pend;
            pend_v <= 1'b0;
          end
        end else begin
          cnt  <= cnt + 1'b1;
          ce_q <= 1'b0;
        end
        if (div_load[g]) begin
          if (rst_out[g]) begin
            act    <= r_in;
            pend_v <= 1'b0;
          end else begin
            pend   <= r_in;
            pend_v <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Directed bench for clock_enable_sequencer (default parameters).
// Release times shift by 16 when CLKGEN_LOCK_FILTER_EN is defined.
module tb_clock_enable_sequencer;

`ifdef CLKGEN_LOCK_FILTER_EN
  localparam int OFF = 16;
`else
  localparam int OFF = 0;
`endif
  localparam int T0 = 35 + OFF;
  localparam int T1 = 51 + OFF;

  logic        clk;
  logic        reset_n;
  logic        pll_locked;
  logic [15:0] div_ratio;
  logic [1:0]  div_load;
  logic [1:0]  ce_out;
  logic [1:0]  clk_div_out;
  logic [1:0]  rst_out;
  logic        all_ready;

  int checks;
  int failures;

  clock_enable_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .div_ratio   (div_ratio),
    .div_load    (div_load),
    .ce_out      (ce_out),
    .clk_div_out (clk_div_out),
    .rst_out     (rst_out),
    .all_ready   (all_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rst_out !== 2'b11 || ce_out !== 2'b00 ||
          clk_div_out !== 2'b00 || all_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_state got=%b_%b_%b_%b exp=11_00_00_0",
                 rst_out, ce_out, clk_div_out, all_ready);
      end
    end
  endtask

  // Starts at +1 after an edge; edge k below counts from the lock raise.
  task automatic run_sequence(input int r0, input logic [15:0] lv,
                              input logic [1:0] lm);
    reset_n    = 1'b1;
    pll_locked = 1'b1;
    div_ratio  = lv;
    div_load   = lm;
    for (int k = 1; k <= 60 + OFF; k++) begin
      @(posedge clk);
      #1;
      div_load = 2'b00;
      if (k == T0 - 1) begin
        checks++;
        if (rst_out !== 2'b11 || ce_out !== 2'b00) begin
          failures++;
          $display("FAIL pre_release k=%0d got=%b_%b exp=11_00",
                   k, rst_out, ce_out);
        end
      end
      if (k == T0) begin
        checks++;
        if (rst_out !== 2'b10) begin
          failures++;
          $display("FAIL rst0_release k=%0d got=%b exp=10", k, rst_out);
        end
      end
      if (k == T1 - 1) begin
        checks++;
        if (rst_out !== 2'b10) begin
          failures++;
          $display("FAIL rst1_hold k=%0d got=%b exp=10", k, rst_out);
        end
      end
      if (k == T1) begin
        checks++;
        if (rst_out !== 2'b00 || all_ready !== 1'b0) begin
          failures++;
          $display("FAIL rst1_release k=%0d got=%b_%b exp=00_0",
                   k, rst_out, all_ready);
        end
      end
      if (k == T1 + 1) begin
        checks++;
        if (all_ready !== 1'b1) begin
          failures++;
          $display("FAIL all_ready k=%0d got=%b exp=1", k, all_ready);
        end
      end
      if (r0 >= 2 && k == T0 + r0 - 2) begin
        checks++;
        if (ce_out[0] !== 1'b0) begin
          failures++;
          $display("FAIL ce0_early k=%0d got=%b exp=0", k, ce_out[0]);
        end
      end
      if (k == T0 + r0 - 1) begin
        checks++;
        if (ce_out[0] !== 1'b1 || clk_div_out[0] !== 1'b1) begin
          failures++;
          $display("FAIL ce0_first k=%0d got=%b_%b exp=1_1",
                   k, ce_out[0], clk_div_out[0]);
        end
      end
      if (k == T0 + 2 * r0 - 2) begin
        checks++;
        if (clk_div_out[0] !== 1'b1) begin
          failures++;
          $display("FAIL div0_high k=%0d got=%b exp=1", k, clk_div_out[0]);
        end
      end
      if (k == T0 + 2 * r0 - 1) begin
        checks++;
        if (ce_out[0] !== 1'b1 || clk_div_out[0] !== 1'b0) begin
          failures++;
          $display("FAIL ce0_second k=%0d got=%b_%b exp=1_0",
                   k, ce_out[0], clk_div_out[0]);
        end
      end
    end
  endtask

  task automatic test_ce_every_cycle(input string name);
    logic prev;
    for (int i = 0; i < 4; i++) begin
      prev = clk_div_out[1];
      @(posedge clk);
      #1;
      checks++;
      if (ce_out[1] !== 1'b1 || clk_div_out[1] !== ~prev) begin
        failures++;
        $display("FAIL %s got=%b_%b exp=1_%b", name,
                 ce_out[1], clk_div_out[1], ~prev);
      end
    end
  endtask

  task automatic test_ratio_one;
    div_ratio[15:8] = 8'd1;
    div_load        = 2'b10;
    @(posedge clk);
    #1;
    div_load = 2'b00;
    test_ce_every_cycle("ratio_one");
  endtask

  task automatic test_ratio_change;
    bit   found;
    logic exp;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ce_out[0] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ratio_find_ce got=0 exp=1");
    end
    for (int j = 1; j <= 27; j++) begin
      div_load = 2'b00;
      if (j == 1) begin
        div_ratio[7:0] = 8'd4;
        div_load       = 2'b01;
      end
      if (j == 10) begin
        div_ratio[7:0] = 8'd9;
        div_load       = 2'b01;
      end
      if (j == 11) begin
        div_ratio[7:0] = 8'd7;
        div_load       = 2'b01;
      end
      @(posedge clk);
      #1;
      exp = (j == 5 || j == 9 || j == 13 || j == 20 || j == 27);
      checks++;
      if (ce_out[0] !== exp) begin
        failures++;
        $display("FAIL ratio_change j=%0d got=%b exp=%b", j, ce_out[0], exp);
      end
    end
    div_load = 2'b00;
  endtask

  task automatic test_lock_loss;
    pll_locked = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) begin
        checks++;
        if (rst_out !== 2'b00) begin
          failures++;
          $display("FAIL lock_loss_early got=%b exp=00", rst_out);
        end
      end
      if (e == 3) begin
        checks++;
        if (rst_out !== 2'b11 || ce_out !== 2'b00 || clk_div_out !== 2'b00) begin
          failures++;
          $display("FAIL lock_loss got=%b_%b_%b exp=11_00_00",
                   rst_out, ce_out, clk_div_out);
        end
      end
      if (e == 4) begin
        checks++;
        if (all_ready !== 1'b0) begin
          failures++;
          $display("FAIL lock_loss_ready got=%b exp=0", all_ready);
        end
      end
    end
    run_sequence(7, div_ratio, 2'b00);
  endtask

  task automatic test_async_reset;
    pll_locked = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    repeat (38 + OFF) @(posedge clk);
    #1;
    checks++;
    if (rst_out !== 2'b10) begin
      failures++;
      $display("FAIL mid_count got=%b exp=10", rst_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rst_out !== 2'b11 || ce_out !== 2'b00 ||
        clk_div_out !== 2'b00 || all_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b_%b_%b_%b exp=11_00_00_0",
               rst_out, ce_out, clk_div_out, all_ready);
    end
    @(posedge clk);
    #1;
    run_sequence(1, 16'h0000, 2'b00);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    div_ratio  = '0;
    div_load   = '0;
    #12;
    test_reset;
    run_sequence(5, 16'h0005, 2'b11);
    test_ce_every_cycle("ratio_zero");
    test_ratio_one;
    test_ratio_change;
    test_lock_loss;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
